// File: rtl/btn_event_decoder.sv
// Turns debounced switch levels into single-cycle press / short / long / repeat
// events, timed in debounce ticks. One independent channel per switch.

module btn_event_chan #(
    parameter int LONG_TICKS   = 10,
    parameter int REPEAT_TICKS = 2,
    parameter int CNT_W        = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic sw_i,
    output logic press_o,
    output logic short_o,
    output logic long_o,
    output logic rpt_o,
    output logic held_o
);
    typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] RPT_TERM  = CNT_W'(REPEAT_TICKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sw_q;
    logic             press_q, press_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             rpt_q, rpt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
        rpt_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // A level already high at reset never counts as a rise.
                if (sw_i && !sw_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (!sw_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end else if (tick_i) begin
                    if (cnt_q == LONG_TERM) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HELD: begin
                if (!sw_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    if (cnt_q == RPT_TERM) begin
                        cnt_d = '0;
                        rpt_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sw_q    <= 1'b1;
            press_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rpt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_i;
            press_q <= press_d;
            short_q <= short_d;
            long_q  <= long_d;
            rpt_q   <= rpt_d;
        end
    end

    assign press_o = press_q;
    assign short_o = short_q;
    assign long_o  = long_q;
    assign rpt_o   = rpt_q;
    assign held_o  = (state_q != IDLE);
endmodule

module btn_event_decoder #(
    parameter int N_SW         = 5,
    parameter int LONG_TICKS   = 10,
    parameter int REPEAT_TICKS = 2,
    parameter int CNT_W        = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            tick_10hz_i,
    input  logic [N_SW-1:0] sw_i,
    output logic [N_SW-1:0] press_pulse_o,
    output logic [N_SW-1:0] short_pulse_o,
    output logic [N_SW-1:0] long_pulse_o,
    output logic [N_SW-1:0] rpt_pulse_o,
    output logic [N_SW-1:0] held_o
);
    for (genvar g = 0; g < N_SW; g++) begin : g_chan
        btn_event_chan #(
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .tick_i (tick_10hz_i),
            .sw_i   (sw_i[g]),
            .press_o(press_pulse_o[g]),
            .short_o(short_pulse_o[g]),
            .long_o (long_pulse_o[g]),
            .rpt_o  (rpt_pulse_o[g]),
            .held_o (held_o[g])
        );
    end
endmodule

// File: tb/tb_btn_event_decoder.sv
// Bench for btn_event_decoder: directed scenarios plus random switching, all
// cycles compared against a tick-counting reference model.

module tb_btn_event_decoder;
    localparam int N  = 5;
    localparam int LT = 10;
    localparam int RT = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick = 1'b0;
    logic [N-1:0] sw = '0;
    logic [N-1:0] press_o, short_o, long_o, rpt_o, held_o;

    btn_event_decoder #(.N_SW(N), .LONG_TICKS(LT), .REPEAT_TICKS(RT), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .tick_10hz_i(tick), .sw_i(sw),
        .press_pulse_o(press_o), .short_pulse_o(short_o), .long_pulse_o(long_o),
        .rpt_pulse_o(rpt_o), .held_o(held_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, phase = 0, tick_cnt = 0, cycn = 0;
    bit rand_tick = 0;

    // Model: per channel, whether a press is active and how many ticks it has seen.
    logic [N-1:0] m_prev = '1, m_act = '0;
    int           m_ticks [N];
    logic [N-1:0] e_press, e_short, e_long, e_rpt;
    logic [24:0]  exp_v = '0;
    wire  [24:0]  act_v = {press_o, short_o, long_o, rpt_o, held_o};

    task automatic cyc();
        tick = (phase == 7) || (rand_tick && $urandom_range(0, 19) == 0);
        phase = (phase + 1) % 8;
        if (tick) tick_cnt++;
        e_press = '0; e_short = '0; e_long = '0; e_rpt = '0;
        if (rst) begin
            m_prev = '1;
            m_act  = '0;
            for (int i = 0; i < N; i++) m_ticks[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!m_act[i]) begin
                    if (sw[i] && !m_prev[i]) begin
                        m_act[i] = 1'b1; m_ticks[i] = 0; e_press[i] = 1'b1;
                    end
                end else if (!sw[i]) begin
                    if (m_ticks[i] < LT) e_short[i] = 1'b1;
                    m_act[i] = 1'b0;
                end else if (tick) begin
                    m_ticks[i]++;
                    if (m_ticks[i] == LT) e_long[i] = 1'b1;
                    else if (m_ticks[i] > LT && (m_ticks[i] - LT) % RT == 0) e_rpt[i] = 1'b1;
                end
                m_prev[i] = sw[i];
            end
        end
        exp_v = {e_press, e_short, e_long, e_rpt, m_act};
        @(posedge clk);
        #1;
        cycn++;
    endtask

    task automatic test_reset();
        rst = 1'b1; sw = '0;
        repeat (3) begin
            cyc();
            checks++;
            if (act_v !== 25'd0) begin
                errors++; $display("FAIL reset cyc=%0d got=%h exp=%h", cycn, act_v, 25'd0);
            end
        end
        rst = 1'b0;
        repeat (2) begin
            cyc(); checks++;
            if (act_v !== exp_v) begin errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
        end
    endtask

    task automatic test_short();
        int t0;
        sw[0] = 1'b1; cyc(); checks++;
        if (press_o !== 5'b00001 || held_o[0] !== 1'b1) begin
            errors++; $display("FAIL short_press cyc=%0d got=%b/%b exp=00001/1", cycn, press_o, held_o[0]);
        end
        t0 = tick_cnt;
        while (tick_cnt < t0 + 3) begin
            cyc(); checks++;
            if (act_v !== exp_v) begin errors++; $display("FAIL short_hold cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
        end
        sw[0] = 1'b0; cyc(); checks++;
        if (short_o[0] !== 1'b1 || long_o[0] !== 1'b0 || held_o[0] !== 1'b0) begin
            errors++; $display("FAIL short_release cyc=%0d got=s%b l%b h%b exp=s1 l0 h0", cycn, short_o[0], long_o[0], held_o[0]);
        end
        repeat (3) begin
            cyc(); checks++;
            if (act_v !== exp_v) begin errors++; $display("FAIL short_after cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
        end
    endtask

    task automatic test_long();
        int t0, nl = 0, nr = 0, lt = -1, r1 = -1;
        sw[2] = 1'b1; cyc(); t0 = tick_cnt;
        checks++;
        if (act_v !== exp_v) begin errors++; $display("FAIL long_press cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
        while (tick_cnt < t0 + 15) begin
            cyc(); checks++;
            if (act_v !== exp_v) begin errors++; $display("FAIL long_hold cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
            if (long_o[2]) begin nl++; lt = tick_cnt - t0; end
            if (rpt_o[2]) begin nr++; if (r1 < 0) r1 = tick_cnt - t0; end
        end
        checks++;
        if (nl != 1 || lt != 10 || nr != 2 || r1 != 12) begin
            errors++; $display("FAIL long_counts got=nl%0d lt%0d nr%0d r1%0d exp=nl1 lt10 nr2 r1 12", nl, lt, nr, r1);
        end
        sw[2] = 1'b0; cyc(); checks++;
        if (short_o[2] !== 1'b0 || held_o[2] !== 1'b0) begin
            errors++; $display("FAIL long_release cyc=%0d got=s%b h%b exp=s0 h0", cycn, short_o[2], held_o[2]);
        end
        cyc();
    endtask

    task automatic test_fall_tick();
        int t0;
        if (phase == 7) cyc();
        sw[1] = 1'b1; cyc(); t0 = tick_cnt;
        while (tick_cnt < t0 + 9 || phase != 7) begin
            cyc(); checks++;
            if (act_v !== exp_v) begin errors++; $display("FAIL falltick_hold cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
        end
        sw[1] = 1'b0; cyc(); checks++;
        if (short_o[1] !== 1'b1 || long_o[1] !== 1'b0 || tick_cnt != t0 + 10) begin
            errors++; $display("FAIL falltick cyc=%0d got=s%b l%b t%0d exp=s1 l0 t10", cycn, short_o[1], long_o[1], tick_cnt - t0);
        end
        cyc();
    endtask

    task automatic test_reset_held();
        logic [N-1:0] seen = '0;
        sw = 5'b11000; rst = 1'b1; cyc(); cyc(); rst = 1'b0;
        repeat (20) begin
            cyc(); seen |= press_o | short_o | long_o | rpt_o | held_o;
        end
        sw = 5'b00000;
        repeat (10) begin
            cyc(); seen |= press_o | short_o | long_o | rpt_o | held_o;
        end
        checks++;
        if (seen !== 5'b0) begin errors++; $display("FAIL rstheld_quiet got=%b exp=00000", seen); end
        sw[4] = 1'b1; cyc(); checks++;
        if (press_o !== 5'b10000 || act_v !== exp_v) begin
            errors++; $display("FAIL rstheld_repress cyc=%0d got=%b exp=10000", cycn, press_o);
        end
        sw[4] = 1'b0; cyc(); cyc();
    endtask

    task automatic test_parallel();
        int t0, nboth = 0, lt = -1;
        while (phase != 7) cyc();
        sw[0] = 1'b1; sw[4] = 1'b1; cyc(); t0 = tick_cnt; checks++;
        if (press_o !== 5'b10001) begin errors++; $display("FAIL par_press cyc=%0d got=%b exp=10001", cycn, press_o); end
        while (tick_cnt < t0 + 10) begin
            cyc(); checks++;
            if (act_v !== exp_v) begin errors++; $display("FAIL par_hold cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
            if (long_o[0] && long_o[4]) begin nboth++; lt = tick_cnt - t0; end
        end
        checks++;
        if (nboth != 1 || lt != 10) begin errors++; $display("FAIL par_long got=n%0d t%0d exp=n1 t10", nboth, lt); end
        sw = '0; cyc(); cyc();
    endtask

    task automatic test_rst_mid_hold();
        int t0;
        logic [1:0] seen = '0;
        sw[2] = 1'b1; cyc(); t0 = tick_cnt;
        while (tick_cnt < t0 + 12) cyc();
        rst = 1'b1; cyc(); rst = 1'b0; checks++;
        if (act_v !== 25'd0) begin errors++; $display("FAIL midrst cyc=%0d got=%h exp=%h", cycn, act_v, 25'd0); end
        repeat (30) begin
            cyc(); seen |= {short_o[2], rpt_o[2]}; checks++;
            if (act_v !== exp_v) begin errors++; $display("FAIL midrst_after cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
        end
        sw[2] = 1'b0; cyc(); seen |= {short_o[2], rpt_o[2]};
        checks++;
        if (seen !== 2'b00) begin errors++; $display("FAIL midrst_quiet got=%b exp=00", seen); end
        sw[2] = 1'b1; cyc(); checks++;
        if (press_o[2] !== 1'b1) begin errors++; $display("FAIL midrst_repress cyc=%0d got=%b exp=1", cycn, press_o[2]); end
        sw[2] = 1'b0; cyc(); cyc();
    endtask

    task automatic test_random();
        rand_tick = 1'b1;
        repeat (1500) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 29) == 0) sw[i] = ~sw[i];
            rst = ($urandom_range(0, 249) == 0);
            cyc(); checks++;
            if (act_v !== exp_v) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cycn, act_v, exp_v); end
        end
        rand_tick = 1'b0; rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_ticks[i] = 0;
        test_reset();
        test_short();
        test_long();
        test_fall_tick();
        test_reset_held();
        test_parallel();
        test_rst_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btn_event_decoder.md
# btn_event_decoder

Converts the five debounced switch levels into single-cycle user-interface events for the clock system's mode/set logic: press, short click, long hold and auto-repeat. It sits directly downstream of the switch debouncer and shares its 10 Hz debounce tick. All timing is counted in ticks, so hold and repeat intervals are independent of `clk` frequency.

## Interface
- `N_SW`, 5, number of switch channels.
- `LONG_TICKS`, 10, ticks held before `long_pulse` fires (1.0 s at 10 Hz); legal range 2..255.
- `REPEAT_TICKS`, 2, ticks between `rpt_pulse` events after a long hold (0.2 s); legal range 1..255.
- `CNT_W`, 8, per-channel tick counter width; must satisfy 2^CNT_W > max(LONG_TICKS, REPEAT_TICKS).
- `clk`  in  1  system clock; the single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `tick_10hz`  in  1  one-`clk`-wide enable pulse at 10 Hz; the same tick that drives the debouncer.
- `sw`  in  N_SW  debounced switch levels, 1 = pressed.
- `press_pulse`  out  N_SW  one-cycle pulse on press.
- `short_pulse`  out  N_SW  one-cycle pulse on release before the long threshold.
- `long_pulse`  out  N_SW  one-cycle pulse when the hold reaches LONG_TICKS.
- `rpt_pulse`  out  N_SW  one-cycle pulse every REPEAT_TICKS while held past long.
- `held`  out  N_SW  level, 1 while the channel FSM is not IDLE.

## Operation
- Each channel is independent and has a previous-level register `sw_q[i]`, an FSM, and a counter `cnt[i]`.
- Rise means `sw[i]=1 && sw_q[i]=0`. Fall means `sw[i]=0`.
- FSM states are IDLE, PRESSED and HELD.
- IDLE, on rise: go to PRESSED, `cnt=0`, `press_pulse=1`.
- PRESSED:
  - Fall: go to IDLE, `cnt=0`, `short_pulse=1`.
  - `tick_10hz` while still pressed: if `cnt==LONG_TICKS-1`, go to HELD, `cnt=0`, `long_pulse=1`; otherwise `cnt++`.
- HELD:
  - Fall: go to IDLE, `cnt=0`. No pulse is emitted.
  - `tick_10hz` while still pressed: if `cnt==REPEAT_TICKS-1`, `rpt_pulse=1`, `cnt=0`; otherwise `cnt++`.
- `held[i]` is 1 whenever state is not IDLE.
- The counter never exceeds its terminal value and never wraps.
- Simultaneous events:
  - Fall and tick in the same cycle: fall wins. No long or repeat pulse is emitted, and `short_pulse` fires if the state was PRESSED.
  - Rise and tick in the same cycle: the tick is ignored and counting starts at the next tick.
  - Events on several channels in the same cycle are all reported in parallel. There is no priority between channels.
- Per channel, at most one of `press/short/long/rpt` is asserted in any cycle.
- `long_pulse` therefore fires on the LONG_TICKS-th tick strictly after the press cycle. The first `rpt_pulse` fires REPEAT_TICKS ticks after `long_pulse`.

## Timing
- All outputs are registered. Latency is 1 `clk` from the edge on which `sw`/`tick_10hz` is sampled to the output.
- Each pulse is exactly one `clk` cycle wide and is never stretched across a tick.
- Reset, evaluated on `clk` while `rst=1`:
  - All outputs are 0.
  - All FSMs are IDLE and all `cnt` are 0.
  - `sw_q` is set to all-ones. A switch held through reset must therefore be released and pressed again before it generates any event. Its release after reset produces no pulse.
- Reset mid-hold aborts the channel with no `short_pulse`.
- `rst` has priority over all inputs in the same cycle.
- `sw` is already synchronous to `clk`, so no internal synchronizer is needed.
- If `tick_10hz` is held high for multiple cycles, each cycle counts as one tick. This is legal but off-spec for the tick source.

## Test plan
Bench setup: LONG_TICKS=10, REPEAT_TICKS=2, `tick_10hz` pulsed every 8 `clk`.

1. Reset with `sw=5'b00000`, then raise `sw[0]` for 3 ticks and drop it -> `press_pulse[0]` 1 cycle after the rise, `short_pulse[0]` 1 cycle after the fall. No `long_pulse`. `held[0]` is high only between those points.
2. Hold `sw[2]` for 15 ticks -> `long_pulse[2]` on the 10th tick after press, then `rpt_pulse[2]` on ticks 12 and 14. On release, no `short_pulse`, and `held[2]` returns to 0.
3. Drop `sw[1]` in the same cycle as its 10th tick -> `short_pulse[1]=1`, `long_pulse[1]=0`.
4. Hold `sw[3]` and `sw[4]` through reset release, then release and re-press `sw[4]` only -> no events until the re-press, then `press_pulse[4]` only. `sw[3]` release produces nothing.
5. Press `sw[0]` and `sw[4]` in the same cycle, with `sw[0]` coinciding with a tick -> both `press_pulse` bits set in the same cycle. `long_pulse[0]` and `long_pulse[4]` arrive together on the 10th following tick.
6. Assert `rst` for 1 cycle while `sw[2]` is in HELD -> all outputs 0 the next cycle, with no `short_pulse`/`rpt_pulse` afterwards until `sw[2]` is released and pressed again.
